seeker_bot_param: RTL
=====================

Name: seeker_bot_param

Overview:
Parametrised maze-chasing seeker for the hide-and-seek game. It replaces the fixed 16x16 seeker that had an internal clock divider and a single greedy policy. This block takes the maze bitmap and the step strobe from outside, and adds a selectable wall-follower mode, a step budget with a hider-wins timeout, and a start/restart handshake. It sits between the level ROM/hider controller and the renderer.

Parameters:
MAZE_W, 16, maze width in cells (>=3)
MAZE_H, 16, maze height in cells (>=3)
CW, 4, coordinate width; must satisfy 2**CW >= max(MAZE_W, MAZE_H)
SC_W, 10, step counter width
MAX_STEPS, 600, step budget; reaching it ends the game with the hider winning

Ports:
clk  in  1  system clock
rst  in  1  reset; clears all state
start  in  1  1-cycle pulse: load start position and begin a game
step_tick  in  1  1-cycle move strobe from the shared clk_divider (an enable, never used as a clock)
mode  in  1  0 = greedy-visited, 1 = right-hand wall follower; sampled at start
maze_data  in  MAZE_W*MAZE_H  1 = wall; cell (x,y) is bit (MAZE_H-1-y)*MAZE_W + (MAZE_W-1-x)
start_x, start_y  in  CW  start cell, sampled at start
hider_x, hider_y  in  CW  hider cell; live input
seeker_x, seeker_y  out  CW  current cell
dir  out  2  last move direction: 0 up (y-1), 1 down, 2 left (x-1), 3 right
moved  out  1  1-cycle pulse when the position changes
done  out  1  game over; sticky until start or rst
winner  out  1  valid when done: 0 = seeker caught hider, 1 = hider survived budget
step_count  out  SC_W  steps taken this game
visited_clr  out  1  1-cycle pulse when the greedy visited map is flushed

Behaviour:
- Reset is asynchronous and active-high, on port rst. Single clock, clk.
- Reset values: seeker_x/seeker_y = 0, dir = 0, moved = 0, done = 0, winner = 0, step_count = 0, visited_clr = 0, visited map all 0, state = IDLE.
- FSM states: IDLE, SENSE, DECIDE, WAIT, OVER.
- IDLE: outputs hold. A start pulse loads the position, clears the visited map, step_count and done, latches mode, and enters WAIT next cycle.
- WAIT: each cycle, check position against hider first. If equal, go to OVER with winner = 0. Otherwise, if step_count == MAX_STEPS, go to OVER with winner = 1. Otherwise a step_tick moves to SENSE.
- Catch takes priority over timeout when both are true in the same cycle.
- SENSE (1 cycle): register four neighbour-free flags. A neighbour is free if it is inside 0..MAZE_W-1 / 0..MAZE_H-1 and not a wall. Out-of-range neighbours are walls, so there is no coordinate wrap.
- DECIDE (1 cycle): compute the move from the registered flags and the current hider position. Update seeker_x/seeker_y, dir and step_count (+1, saturating), pulse moved, then return to WAIT.
- Move-to-catch latency: the new position is visible 3 cycles after step_tick; catch is detected the following cycle.
- Greedy mode (0):
  - Mark the current cell visited.
  - Candidates are free neighbours not yet visited.
  - Pick the candidate with the strictly smallest Manhattan distance to the hider. Distance is computed CW+1 bits wide with no overflow.
  - If no candidate beats the current distance, take the first candidate in priority order up, down, left, right.
  - If there are no candidates: clear the visited map, pulse visited_clr, make no move, and do not increment step_count.
  - dir always reflects the direction actually taken.
- Wall-follower mode (1): keep a heading, initialised to up at start.
  - Try right-of-heading, then straight, then left, then reverse; take the first free one.
  - Heading becomes the direction taken. The visited map is unused.
- Fully enclosed cell: no move, no pulse, step_count unchanged.
- step_tick during SENSE, DECIDE, OVER or IDLE is dropped, never queued.
- OVER: done = 1, position frozen, and further ticks are ignored. Only start (restart) or rst leaves OVER.
- start in any state restarts the game immediately. It overrides a concurrent tick.
- rst mid-DECIDE: all outputs return to their reset values asynchronously.
- The hider position is not registered and is read live in WAIT and DECIDE.

Decomposition:
- Package seeker_pkg:
  - dir encodings DIR_UP/DOWN/LEFT/RIGHT
  - mode encodings MODE_GREEDY/MODE_WALL
  - FSM state encoding
  - a manhattan-distance function
- Sub-module maze_neighbour_sense: combinational. Inputs are the maze bitmap and a coordinate; output is the four free flags with bounds handling. It is reused by the hider AI and the collision checker.

Test Plan:
- Open maze (border walls, interior free), mode 0, start (14,14), hider fixed (1,14), tick every 8 cycles -> dir=2 every step; after 13 moves done=1, winner=0, step_count=13, position (1,14).
- Same maze, MAX_STEPS=4, hider (1,1) -> exactly 4 moved pulses, then done=1, winner=1, step_count=4; later ticks change nothing.
- Dead-end corridor 1 cell wide, start at the tip, hider behind the wall -> visited_clr pulses once with no position change and no step_count increment that tick; movement resumes on the next tick.
- Mode 1, 3x3 free room bordered by walls, start (1,1), hider unreachable -> sequence follows the right-hand rule and repeats with period equal to the perimeter; step_count increments every tick.
- Asynchronous rst asserted mid-DECIDE, then start with (5,5) -> outputs zero immediately; the new game begins at (5,5) with step_count=0.
- step_tick in the same cycle as start, and a tick during SENSE -> tick ignored; only one move per accepted tick.

Source files
------------

// File: rtl/seeker_pkg.sv
// Shared encodings and helpers for the maze seeker and its neighbours.
// The distance type is wide enough for any supported coordinate width.
package seeker_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        MODE_GREEDY = 1'b0,
        MODE_WALL   = 1'b1
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SENSE,
        ST_DECIDE,
        ST_WAIT,
        ST_OVER
    } state_t;

    localparam int DIST_CW = 15;
    typedef logic [DIST_CW-1:0] coord_t;
    typedef logic [DIST_CW:0]   dist_t;

    // One extra bit over the coordinate width, so |dx|+|dy| never overflows.
    function automatic dist_t manhattan(coord_t ax, coord_t ay, coord_t bx, coord_t by);
        coord_t dx;
        coord_t dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return dist_t'(dx) + dist_t'(dy);
    endfunction

    function automatic dir_t turn_right(dir_t d);
        case (d)
            DIR_UP:   return DIR_RIGHT;
            DIR_RIGHT: return DIR_DOWN;
            DIR_DOWN: return DIR_LEFT;
            default:  return DIR_UP;
        endcase
    endfunction

    function automatic dir_t turn_left(dir_t d);
        case (d)
            DIR_UP:   return DIR_LEFT;
            DIR_LEFT: return DIR_DOWN;
            DIR_DOWN: return DIR_RIGHT;
            default:  return DIR_UP;
        endcase
    endfunction

    function automatic dir_t reverse(dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/maze_neighbour_sense.sv
// Combinational free-flag lookup for the four neighbours of a maze cell.
// Anything outside the maze counts as wall, so coordinates never wrap.
module maze_neighbour_sense
    import seeker_pkg::*;
#(
    parameter int MAZE_W = 16,
    parameter int MAZE_H = 16,
    parameter int CW     = 4
) (
    input  logic [MAZE_W*MAZE_H-1:0] i_maze,
    input  logic [CW-1:0]            i_x,
    input  logic [CW-1:0]            i_y,
    output logic [3:0]               o_free
);

    function automatic logic cell_free(logic [MAZE_W*MAZE_H-1:0] maze, int cx, int cy);
        logic [MAZE_W*MAZE_H-1:0] shifted;
        if (cx < 0 || cx >= MAZE_W || cy < 0 || cy >= MAZE_H) return 1'b0;
        shifted = maze >> ((MAZE_H - 1 - cy) * MAZE_W + (MAZE_W - 1 - cx));
        return ~shifted[0];
    endfunction

    always_comb begin
        o_free[DIR_UP]    = cell_free(i_maze, int'(i_x),     int'(i_y) - 1);
        o_free[DIR_DOWN]  = cell_free(i_maze, int'(i_x),     int'(i_y) + 1);
        o_free[DIR_LEFT]  = cell_free(i_maze, int'(i_x) - 1, int'(i_y));
        o_free[DIR_RIGHT] = cell_free(i_maze, int'(i_x) + 1, int'(i_y));
    end

endmodule

// File: rtl/seeker_bot_param.sv
// Maze seeker: greedy-visited or right-hand wall-follower chase of a live hider,
// with a step budget that hands the game to the hider when exhausted.
module seeker_bot_param
    import seeker_pkg::*;
#(
    parameter int MAZE_W    = 16,
    parameter int MAZE_H    = 16,
    parameter int CW        = 4,
    parameter int SC_W      = 10,
    parameter int MAX_STEPS = 600
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step_tick,
    input  logic                     mode,
    input  logic [MAZE_W*MAZE_H-1:0] maze_data,
    input  logic [CW-1:0]            start_x,
    input  logic [CW-1:0]            start_y,
    input  logic [CW-1:0]            hider_x,
    input  logic [CW-1:0]            hider_y,
    output logic [CW-1:0]            seeker_x,
    output logic [CW-1:0]            seeker_y,
    output logic [1:0]               dir,
    output logic                     moved,
    output logic                     done,
    output logic                     winner,
    output logic [SC_W-1:0]          step_count,
    output logic                     visited_clr
);

    localparam int              NCELL      = MAZE_W * MAZE_H;
    localparam logic [SC_W-1:0] STEP_LIMIT = SC_W'(MAX_STEPS);

    state_t          r_state, w_next_state;
    logic [CW-1:0]   r_x, r_y, w_nx, w_ny;
    dir_t            r_dir, r_heading, w_move_dir;
    mode_t           r_mode;
    logic            r_moved, r_done, r_winner, r_vclr;
    logic [SC_W-1:0] r_step;
    logic [3:0]      r_free, w_free;
    logic [NCELL-1:0] r_visited, w_cur_mask;
    logic            w_catch, w_timeout, w_move, w_flush;

    maze_neighbour_sense #(.MAZE_W(MAZE_W), .MAZE_H(MAZE_H), .CW(CW)) u_sense (
        .i_maze (maze_data),
        .i_x    (r_x),
        .i_y    (r_y),
        .o_free (w_free)
    );

    function automatic logic [2*CW-1:0] neighbour(logic [CW-1:0] x, logic [CW-1:0] y, dir_t d);
        logic [CW-1:0] nx;
        logic [CW-1:0] ny;
        nx = x;
        ny = y;
        case (d)
            DIR_UP:   ny = y - CW'(1);
            DIR_DOWN: ny = y + CW'(1);
            DIR_LEFT: nx = x - CW'(1);
            default:  nx = x + CW'(1);
        endcase
        return {nx, ny};
    endfunction

    function automatic logic is_visited(logic [NCELL-1:0] map, int cx, int cy);
        logic [NCELL-1:0] shifted;
        if (cx < 0 || cx >= MAZE_W || cy < 0 || cy >= MAZE_H) return 1'b1;
        shifted = map >> (cy * MAZE_W + cx);
        return shifted[0];
    endfunction

    assign w_cur_mask = NCELL'(1) << (int'(r_y) * MAZE_W + int'(r_x));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_catch      = 1'b0;
        w_timeout    = 1'b0;
        if (start) begin
            w_next_state = ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_x == hider_x && r_y == hider_y) begin
                        w_catch      = 1'b1;
                        w_next_state = ST_OVER;
                    end else if (r_step == STEP_LIMIT) begin
                        w_timeout    = 1'b1;
                        w_next_state = ST_OVER;
                    end else if (step_tick) begin
                        w_next_state = ST_SENSE;
                    end
                end
                ST_SENSE:  w_next_state = ST_DECIDE;
                ST_DECIDE: w_next_state = ST_WAIT;
                default:   ;
            endcase
        end
    end

    always_comb begin : decide_logic
        logic [2*CW-1:0] nb;
        dir_t            try_dir;
        dir_t            first_dir;
        dist_t           best_dist;
        dist_t           cand_dist;
        logic            first_valid;
        logic            found;
        w_move      = 1'b0;
        w_move_dir  = DIR_UP;
        w_flush     = 1'b0;
        try_dir     = DIR_UP;
        first_dir   = DIR_UP;
        first_valid = 1'b0;
        found       = 1'b0;
        nb          = '0;
        cand_dist   = '0;
        best_dist   = manhattan(coord_t'(r_x), coord_t'(r_y), coord_t'(hider_x), coord_t'(hider_y));
        if (r_mode == MODE_GREEDY) begin
            for (int d = 0; d < 4; d++) begin
                try_dir = dir_t'(d[1:0]);
                nb      = neighbour(r_x, r_y, try_dir);
                if (r_free[try_dir] && !is_visited(r_visited, int'(nb[2*CW-1:CW]), int'(nb[CW-1:0]))) begin
                    if (!first_valid) begin
                        first_valid = 1'b1;
                        first_dir   = try_dir;
                    end
                    cand_dist = manhattan(coord_t'(nb[2*CW-1:CW]), coord_t'(nb[CW-1:0]),
                                          coord_t'(hider_x), coord_t'(hider_y));
                    if (cand_dist < best_dist) begin
                        best_dist  = cand_dist;
                        w_move_dir = try_dir;
                        found      = 1'b1;
                    end
                end
            end
            if (found) begin
                w_move = 1'b1;
            end else if (first_valid) begin
                w_move     = 1'b1;
                w_move_dir = first_dir;
            end else if (|r_free) begin
                // Boxed in by our own trail: forget it and try again next tick.
                w_flush = 1'b1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0:       try_dir = turn_right(r_heading);
                    1:       try_dir = r_heading;
                    2:       try_dir = turn_left(r_heading);
                    default: try_dir = reverse(r_heading);
                endcase
                if (!w_move && r_free[try_dir]) begin
                    w_move     = 1'b1;
                    w_move_dir = try_dir;
                end
            end
        end
        nb   = neighbour(r_x, r_y, w_move_dir);
        w_nx = nb[2*CW-1:CW];
        w_ny = nb[CW-1:0];
    end

    // NOTE: the visited map is reset with the rest of the state so a fresh game never sees stale marks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_dir     <= DIR_UP;
            r_heading <= DIR_UP;
            r_mode    <= MODE_GREEDY;
            r_moved   <= 1'b0;
            r_done    <= 1'b0;
            r_winner  <= 1'b0;
            r_vclr    <= 1'b0;
            r_step    <= '0;
            r_free    <= '0;
            r_visited <= '0;
        end else begin
            r_moved <= 1'b0;
            r_vclr  <= 1'b0;
            if (start) begin
                r_x       <= start_x;
                r_y       <= start_y;
                r_visited <= '0;
                r_step    <= '0;
                r_done    <= 1'b0;
                r_winner  <= 1'b0;
                r_mode    <= mode_t'(mode);
                r_heading <= DIR_UP;
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (w_catch) begin
                            r_done   <= 1'b1;
                            r_winner <= 1'b0;
                        end else if (w_timeout) begin
                            r_done   <= 1'b1;
                            r_winner <= 1'b1;
                        end
                    end
                    ST_SENSE: r_free <= w_free;
                    ST_DECIDE: begin
                        if (r_mode == MODE_GREEDY)
                            r_visited <= w_flush ? '0 : (r_visited | w_cur_mask);
                        r_vclr <= w_flush;
                        if (w_move) begin
                            r_x       <= w_nx;
                            r_y       <= w_ny;
                            r_dir     <= w_move_dir;
                            r_heading <= w_move_dir;
                            r_moved   <= 1'b1;
                            r_step    <= (r_step == '1) ? r_step : r_step + SC_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign seeker_x    = r_x;
    assign seeker_y    = r_y;
    assign dir         = r_dir;
    assign moved       = r_moved;
    assign done        = r_done;
    assign winner      = r_winner;
    assign step_count  = r_step;
    assign visited_clr = r_vclr;

endmodule
